world_rect_writer: RTL and testbench

- Write-side engine for the 2000x120, 3-bit-per-pixel scrolling world RAM. The VGA scroll datapath reads from the same RAM.
- Stamps a solid-colour rectangle (platform, obstacle, erase patch) into world coordinates, one pixel per clock, row-major.
- Drives the RAM write port (address/data/wren) under a start/busy/done handshake from the game-control FSM.

---
 rtl/world_rect_writer_if.sv | 40 ++++
 rtl/world_rect_writer.sv | 201 ++++++++++++++++++++
 tb/tb_world_rect_writer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/world_rect_writer_if.sv
// world_rect_writer_if
//   Request/response bundle between the game-control FSM and the world
//   rectangle writer, plus the world RAM write port the writer drives.
//   master : game control (drives the request, observes busy/done and the RAM port)
//   slave  : world_rect_writer
//   Signals:
//     start        request pulse, sampled only while the writer is idle
//     x0, y0       rectangle top-left corner in world coordinates
//     w, h         rectangle size in pixels
//     fill_color   3-bit colour stamped into every pixel
//     ram_address  RAM write address (y*WORLD_W + x)
//     ram_data     RAM write data
//     ram_wren     RAM write enable, one pixel per high cycle
//     busy         request in progress
//     done         single-cycle completion pulse
interface world_rect_writer_if #(
   parameter int AW = 18
) ();
   logic          start;
   logic [10:0]   x0;
   logic [6:0]    y0;
   logic [7:0]    w;
   logic [6:0]    h;
   logic [2:0]    fill_color;
   logic [AW-1:0] ram_address;
   logic [2:0]    ram_data;
   logic          ram_wren;
   logic          busy;
   logic          done;

   modport master (
      output start, x0, y0, w, h, fill_color,
      input  ram_address, ram_data, ram_wren, busy, done
   );

   modport slave (
      input  start, x0, y0, w, h, fill_color,
      output ram_address, ram_data, ram_wren, busy, done
   );
endinterface

// File: rtl/world_rect_writer.sv
// world_rect_writer
//   Stamps a solid-colour rectangle into the 2000x120, 3-bit-per-pixel
//   scrolling world RAM, one pixel per clock in row-major order. The
//   rectangle is clipped to the world; nothing wraps into the next row.
//   Ports:
//     CLOCK_50  system clock, rising edge
//     reset     synchronous, active-high
//     bus       world_rect_writer_if slave modport (request in, RAM port and
//               busy/done out)
//   All outputs are registered; they are loaded from the next-state
//   decision so that each output matches the state being entered.
module world_rect_writer #(
   parameter int WORLD_W = 2000,
   parameter int WORLD_H = 120,
   parameter int AW      = 18
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   world_rect_writer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [AW-1:0] STRIDE = AW'(WORLD_W);

   state_t        state_r, state_next_s;

   // latched request
   logic [10:0]   x0_r;
   logic [6:0]    y0_r;
   logic [7:0]    w_r;
   logic [6:0]    h_r;
   logic [2:0]    color_r;

   // raster cursor: (x_r, y_r) is the pixel currently on the RAM port
   logic [11:0]   x_r, x_next_s;
   logic [7:0]    y_r, y_next_s;
   logic [AW-1:0] row_base_r, row_base_next_s;
   logic [11:0]   x_end_r, x_end_s;
   logic [7:0]    y_end_r, y_end_s;

   // registered outputs
   logic [AW-1:0] ram_address_r, addr_next_s;
   logic [2:0]    ram_data_r;
   logic          ram_wren_r, wren_next_s;
   logic          busy_r;
   logic          done_r, done_next_s;

   logic          latch_s;
   logic          empty_s;
   logic          last_col_s;
   logic          last_row_s;
   logic [11:0]   x_sum_s;
   logic [7:0]    y_sum_s;
   logic [AW-1:0] setup_base_s;

   // Clip bounds, empty-request detection and next-state/datapath decisions.
   always_comb begin
      state_next_s    = state_r;
      x_next_s        = x_r;
      y_next_s        = y_r;
      row_base_next_s = row_base_r;
      addr_next_s     = ram_address_r;
      wren_next_s     = 1'b0;
      done_next_s     = 1'b0;
      latch_s         = 1'b0;

      // widened sums cannot overflow: 2047+255 < 4096, 127+127 < 256
      x_sum_s = {1'b0, x0_r} + {4'b0000, w_r};
      y_sum_s = {1'b0, y0_r} + {1'b0, h_r};
      if (x_sum_s > 12'(WORLD_W)) begin
         x_end_s = 12'(WORLD_W);
      end else begin
         x_end_s = x_sum_s;
      end
      if (y_sum_s > 8'(WORLD_H)) begin
         y_end_s = 8'(WORLD_H);
      end else begin
         y_end_s = y_sum_s;
      end

      empty_s = (w_r == 8'd0) || (h_r == 7'd0) ||
                (x0_r >= 11'(WORLD_W)) || (y0_r >= 7'(WORLD_H));

      // only multiply in the single SETUP cycle; the raster loop is incremental
      setup_base_s = AW'(y0_r) * STRIDE;

      last_col_s = (x_r == x_end_r - 12'd1);
      last_row_s = (y_r == y_end_r - 8'd1);

      case (state_r)
         IDLE: begin
            if (bus.start) begin
               latch_s      = 1'b1;
               state_next_s = SETUP;
            end else begin
               state_next_s = IDLE;
            end
         end
         SETUP: begin
            if (empty_s) begin
               state_next_s = DONE;
               done_next_s  = 1'b1;
            end else begin
               state_next_s    = WRITE;
               wren_next_s     = 1'b1;
               x_next_s        = {1'b0, x0_r};
               y_next_s        = {1'b0, y0_r};
               row_base_next_s = setup_base_s;
               addr_next_s     = setup_base_s + AW'(x0_r);
            end
         end
         WRITE: begin
            if (last_col_s && last_row_s) begin
               state_next_s = DONE;
               done_next_s  = 1'b1;
            end else if (last_col_s) begin
               state_next_s    = WRITE;
               wren_next_s     = 1'b1;
               x_next_s        = {1'b0, x0_r};
               y_next_s        = y_r + 8'd1;
               row_base_next_s = row_base_r + STRIDE;
               addr_next_s     = row_base_r + STRIDE + AW'(x0_r);
            end else begin
               state_next_s = WRITE;
               wren_next_s  = 1'b1;
               x_next_s     = x_r + 12'd1;
               addr_next_s  = row_base_r + AW'(x_r + 12'd1);
            end
         end
         DONE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, cursor and output registers; reset clears everything to idle.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r       <= IDLE;
         x_r           <= 12'd0;
         y_r           <= 8'd0;
         row_base_r    <= '0;
         x_end_r       <= 12'd0;
         y_end_r       <= 8'd0;
         ram_address_r <= '0;
         ram_data_r    <= 3'd0;
         ram_wren_r    <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         x_r           <= x_next_s;
         y_r           <= y_next_s;
         row_base_r    <= row_base_next_s;
         if (state_r == SETUP) begin
            x_end_r <= x_end_s;
            y_end_r <= y_end_s;
         end
         ram_address_r <= addr_next_s;
         if (wren_next_s) begin
            ram_data_r <= color_r;
         end
         ram_wren_r    <= wren_next_s;
         busy_r        <= (state_next_s != IDLE);
         done_r        <= done_next_s;
      end
   end

   // Request latch; later input changes cannot disturb a running request.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         x0_r    <= 11'd0;
         y0_r    <= 7'd0;
         w_r     <= 8'd0;
         h_r     <= 7'd0;
         color_r <= 3'd0;
      end else if (latch_s) begin
         x0_r    <= bus.x0;
         y0_r    <= bus.y0;
         w_r     <= bus.w;
         h_r     <= bus.h;
         color_r <= bus.fill_color;
      end
   end

   assign bus.ram_address = ram_address_r;
   assign bus.ram_data    = ram_data_r;
   assign bus.ram_wren    = ram_wren_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;

endmodule

// File: tb/tb_world_rect_writer.sv
// tb_world_rect_writer
//   Directed, table-driven bench for world_rect_writer. Each table record
//   holds a request and its hand-computed write count, first/last address
//   and address sum. Hand-written sequences cover reset state, start while
//   busy and reset in the middle of a write.
//   Sample index k means "observed #1 after the k-th rising edge following
//   the start edge": writes appear at k=1..N, done at k=N+1, busy low at N+2.
module tb_world_rect_writer;

   logic CLOCK_50;
   logic reset;

   world_rect_writer_if #(.AW(18)) bus ();

   world_rect_writer #(
      .WORLD_W (2000),
      .WORLD_H (120),
      .AW      (18)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #10 CLOCK_50 = ~CLOCK_50;
   end

   typedef struct {
      int x0;
      int y0;
      int w;
      int h;
      int col;
      int n;
      int first;
      int last;
      int sum;
   } vec_t;

   vec_t vecs [11];

   int n_cmp;
   int n_bad;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Issue one request and observe it until 6 cycles past done (or timeout).
   task automatic run_req(input int x0, input int y0, input int w, input int h,
                          input int col, input int repulse_at,
                          output int n, output int first, output int last,
                          output int sum, output int bad_data, output int max_a,
                          output int done_k, output int n_done, output int busy0,
                          output int busy_after, output int extra);
      bus.x0         = 11'(x0);
      bus.y0         = 7'(y0);
      bus.w          = 8'(w);
      bus.h          = 7'(h);
      bus.fill_color = 3'(col);
      bus.start      = 1'b1;
      @(posedge CLOCK_50);
      #1;
      bus.start  = 1'b0;
      busy0      = int'(bus.busy);
      n          = 0;
      first      = -1;
      last       = -1;
      sum        = 0;
      bad_data   = 0;
      max_a      = 0;
      done_k     = -1;
      n_done     = 0;
      busy_after = -1;
      extra      = 0;
      for (int k = 1; k <= 400; k++) begin
         if (k == repulse_at) begin
            bus.start = 1'b1;
            bus.x0    = 11'd900;
            bus.w     = 8'd7;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge CLOCK_50);
         #1;
         if (bus.ram_wren) begin
            if (done_k >= 0) begin
               extra++;
            end else begin
               if (first < 0) first = int'(bus.ram_address);
               last = int'(bus.ram_address);
               sum  = sum + int'(bus.ram_address);
               n++;
               if (int'(bus.ram_address) > max_a) max_a = int'(bus.ram_address);
               if (int'(bus.ram_data) != col) bad_data++;
            end
         end
         if (bus.done) begin
            n_done++;
            if (done_k < 0) done_k = k;
         end
         if (done_k >= 0 && k == done_k + 1) busy_after = int'(bus.busy);
         if (done_k >= 0 && k >= done_k + 6) break;
      end
      bus.start = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input vec_t v, input int repulse_at);
      int n, first, last, sum, bad_data, max_a, done_k, n_done, busy0, busy_after, extra;
      run_req(v.x0, v.y0, v.w, v.h, v.col, repulse_at, n, first, last, sum,
              bad_data, max_a, done_k, n_done, busy0, busy_after, extra);
      check({tag, " writes"},      n,          v.n);
      check({tag, " first_addr"},  first,      v.first);
      check({tag, " last_addr"},   last,       v.last);
      check({tag, " addr_sum"},    sum,        v.sum);
      check({tag, " data"},        bad_data,   0);
      check({tag, " addr_range"},  int'(max_a < 240000), 1);
      check({tag, " done_cycle"},  done_k,     v.n + 1);
      check({tag, " done_pulses"}, n_done,     1);
      check({tag, " busy_start"},  busy0,      1);
      check({tag, " busy_after"},  busy_after, 0);
      check({tag, " late_writes"}, extra,      0);
   endtask

   initial begin
      vec_t v;
      n_cmp = 0;
      n_bad = 0;

      //            x0    y0   w    h    col  n   first   last    sum
      vecs[0]  = '{10,   5,   2,   2,   5,   4,  10010,  12011,  44042};
      vecs[1]  = '{1998, 0,   5,   2,   3,   4,  1998,   3999,   11994};
      vecs[2]  = '{0,    118, 1,   10,  7,   2,  236000, 238000, 474000};
      vecs[3]  = '{2000, 0,   4,   4,   1,   0,  -1,     -1,     0};
      vecs[4]  = '{5,    5,   0,   3,   2,   0,  -1,     -1,     0};
      vecs[5]  = '{5,    5,   3,   0,   2,   0,  -1,     -1,     0};
      vecs[6]  = '{0,    0,   1,   1,   1,   1,  0,      0,      0};
      vecs[7]  = '{1999, 119, 255, 127, 2,   1,  239999, 239999, 239999};
      vecs[8]  = '{100,  0,   3,   1,   6,   3,  100,    102,    303};
      vecs[9]  = '{0,    120, 1,   1,   4,   0,  -1,     -1,     0};
      vecs[10] = '{1990, 117, 10,  3,   4,   30, 235990, 239999, 7139835};

      bus.start      = 1'b0;
      bus.x0         = 11'd0;
      bus.y0         = 7'd0;
      bus.w          = 8'd0;
      bus.h          = 7'd0;
      bus.fill_color = 3'd0;
      reset          = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      #1;
      check("reset wren", int'(bus.ram_wren),    0);
      check("reset busy", int'(bus.busy),        0);
      check("reset done", int'(bus.done),        0);
      check("reset addr", int'(bus.ram_address), 0);
      check("reset data", int'(bus.ram_data),    0);
      reset = 1'b0;
      @(posedge CLOCK_50);
      #1;

      for (int i = 0; i < 11; i++) begin
         run_and_check($sformatf("vec%0d", i), vecs[i], 0);
      end

      // start re-pulsed (different x0) during a 4x1 write must be ignored
      v = '{50, 2, 4, 1, 3, 4, 4050, 4053, 16206};
      run_and_check("busy_restart", v, 2);
      // a fresh request after busy falls is accepted normally
      v = '{60, 3, 2, 1, 6, 2, 6060, 6061, 12121};
      run_and_check("after_busy", v, 0);

      // reset on the 3rd write cycle of an 8x1 request
      bus.x0         = 11'd20;
      bus.y0         = 7'd1;
      bus.w          = 8'd8;
      bus.h          = 7'd1;
      bus.fill_color = 3'd3;
      bus.start      = 1'b1;
      @(posedge CLOCK_50);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #1;
      check("midrst 3rd wren", int'(bus.ram_wren),    1);
      check("midrst 3rd addr", int'(bus.ram_address), 2022);
      reset = 1'b1;
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
      check("midrst wren", int'(bus.ram_wren),    0);
      check("midrst busy", int'(bus.busy),        0);
      check("midrst done", int'(bus.done),        0);
      check("midrst addr", int'(bus.ram_address), 0);
      check("midrst data", int'(bus.ram_data),    0);
      repeat (3) @(posedge CLOCK_50);
      #1;
      check("midrst idle wren", int'(bus.ram_wren), 0);
      v = '{7, 9, 3, 2, 5, 6, 18007, 20009, 114048};
      run_and_check("after_reset", v, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
